// File: rtl/row_conv_mac_if.sv
// Handshake/control bundle for row_conv_mac: config and start in, weight and IA
// streams in, partial-sum stream out.
interface row_conv_mac_if #(
  parameter int INPUT_BW     = 8,
  parameter int PSUM_BW      = 32,
  parameter int PSUM_ADDR_BW = 12
);
  logic                       start;
  logic [2:0]                 cfg_k;
  logic [5:0]                 cfg_img_w;
  logic [6:0]                 cfg_oc;
  logic [1:0]                 cfg_stride;
  logic                       busy;
  logic                       done;
  logic                       cfg_err;
  logic signed [INPUT_BW-1:0] weight_data;
  logic                       weight_valid;
  logic                       weight_ready;
  logic signed [INPUT_BW-1:0] ia_data;
  logic                       ia_valid;
  logic                       ia_ready;
  logic signed [PSUM_BW-1:0]  psum_data;
  logic [PSUM_ADDR_BW-1:0]    psum_addr;
  logic                       psum_valid;
  logic                       psum_ready;

  modport master (
    output start, cfg_k, cfg_img_w, cfg_oc, cfg_stride,
    output weight_data, weight_valid, ia_data, ia_valid, psum_ready,
    input  busy, done, cfg_err, weight_ready, ia_ready,
    input  psum_data, psum_addr, psum_valid
  );

  modport slave (
    input  start, cfg_k, cfg_img_w, cfg_oc, cfg_stride,
    input  weight_data, weight_valid, ia_data, ia_valid, psum_ready,
    output busy, done, cfg_err, weight_ready, ia_ready,
    output psum_data, psum_addr, psum_valid
  );
endinterface

// File: rtl/row_conv_mac.sv
// 1-D row convolution engine: preloads OC*K weights, slides a K-tap window over an
// IA row with programmable stride and streams one partial sum per output channel.
module row_conv_mac #(
  parameter int INPUT_BW     = 8,
  parameter int PSUM_BW      = 32,
  parameter int MAX_K        = 3,
  parameter int MAX_OC       = 64,
  parameter int MAX_W        = 32,
  parameter int PSUM_ADDR_BW = 12
) (
  input  logic          clk,
  input  logic          reset,
  row_conv_mac_if.slave bus
);
  localparam int         WDEPTH = MAX_OC * MAX_K;
  localparam int         WIDX   = $clog2(WDEPTH);
  localparam logic [2:0] K_LIM  = 3'(MAX_K);
  localparam logic [5:0] W_LIM  = 6'(MAX_W);
  localparam logic [6:0] OC_LIM = 7'(MAX_OC);

  typedef enum logic [2:0] {IDLE, LOAD_W, FILL, EMIT, DRAIN} state_t;
  state_t state, state_nxt;

  logic [2:0]                 k_q;
  logic [5:0]                 img_w_q;
  logic [6:0]                 oc_q;
  logic [1:0]                 stride_q;
  logic [2:0]                 w_tap;
  logic [6:0]                 w_oc;
  logic [5:0]                 px_cnt;
  logic [6:0]                 win_col;
  logic [6:0]                 oc_cnt;
  logic [PSUM_ADDR_BW-1:0]    addr_cnt;
  logic signed [INPUT_BW-1:0] win   [MAX_K];
  logic signed [INPUT_BW-1:0] w_mem [WDEPTH];
  logic signed [PSUM_BW-1:0]  psum_q;
  logic [PSUM_ADDR_BW-1:0]    addr_q;
  logic                       valid_q;
  logic                       done_q;
  logic                       err_q;

  logic cfg_ok, w_fire, w_last, ia_fire, win_hit, all_in, load, last_oc, more_win;
  logic signed [PSUM_BW-1:0]    dot;
  logic signed [2*INPUT_BW-1:0] prod;

  assign cfg_ok = (bus.cfg_k != 3'd0) && (bus.cfg_k <= K_LIM)
               && (bus.cfg_img_w >= {3'b000, bus.cfg_k}) && (bus.cfg_img_w <= W_LIM)
               && (bus.cfg_oc != 7'd0) && (bus.cfg_oc <= OC_LIM)
               && (bus.cfg_stride != 2'd0);

  assign w_fire   = bus.weight_valid && bus.weight_ready;
  assign w_last   = (w_oc == oc_q - 7'd1) && (w_tap == k_q - 3'd1);
  assign ia_fire  = bus.ia_valid && bus.ia_ready;
  assign win_hit  = (state == FILL) && ia_fire && ({1'b0, px_cnt} == win_col);
  assign all_in   = (px_cnt == img_w_q);
  assign load     = (state == EMIT) && (!valid_q || bus.psum_ready);
  assign last_oc  = (oc_cnt == oc_q - 7'd1);
  // Another window fits when its last column still lies inside the row.
  assign more_win = (win_col + 7'(stride_q)) < {1'b0, img_w_q};

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    dot  = '0;
    prod = '0;
    for (int t = 0; t < MAX_K; t++) begin
      if (t < int'(k_q)) begin
        prod = win[t] * w_mem[WIDX'(oc_cnt) * WIDX'(MAX_K) + WIDX'(t)];
        dot  = dot + PSUM_BW'(prod);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start && cfg_ok) state_nxt = LOAD_W;
      LOAD_W:  if (w_fire && w_last)    state_nxt = FILL;
      FILL:    if (win_hit)             state_nxt = EMIT;
      EMIT:    if (load && last_oc)     state_nxt = more_win ? FILL : DRAIN;
      DRAIN:   if (all_in && !valid_q)  state_nxt = IDLE;
      default:                          state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.weight_ready = (state == LOAD_W);
    bus.ia_ready     = (state == FILL) || ((state == DRAIN) && !all_in);
    bus.busy         = (state != IDLE);
    bus.done         = done_q;
    bus.cfg_err      = err_q;
    bus.psum_data    = psum_q;
    bus.psum_addr    = addr_q;
    bus.psum_valid   = valid_q;
  end

  // NOTE: the weight buffer has no reset; it is always fully rewritten before use.
  always_ff @(posedge clk) begin
    if (w_fire) w_mem[WIDX'(w_oc) * WIDX'(MAX_K) + WIDX'(w_tap)] <= bus.weight_data;
  end

  // NOTE: all sequential state uses non-blocking assignments.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k_q      <= '0;
      img_w_q  <= '0;
      oc_q     <= '0;
      stride_q <= '0;
      w_tap    <= '0;
      w_oc     <= '0;
      px_cnt   <= '0;
      win_col  <= '0;
      oc_cnt   <= '0;
      addr_cnt <= '0;
      psum_q   <= '0;
      addr_q   <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      for (int t = 0; t < MAX_K; t++) win[t] <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (load)                valid_q <= 1'b1;
      else if (bus.psum_ready) valid_q <= 1'b0;

      case (state)
        IDLE: if (bus.start) begin
          if (cfg_ok) begin
            k_q      <= bus.cfg_k;
            img_w_q  <= bus.cfg_img_w;
            oc_q     <= bus.cfg_oc;
            stride_q <= bus.cfg_stride;
            w_tap    <= '0;
            w_oc     <= '0;
            px_cnt   <= '0;
            win_col  <= 7'(bus.cfg_k) - 7'd1;
            oc_cnt   <= '0;
            addr_cnt <= '0;
          end else begin
            err_q <= 1'b1;
          end
        end
        LOAD_W: if (w_fire) begin
          if (w_tap == k_q - 3'd1) begin
            w_tap <= '0;
            w_oc  <= w_oc + 7'd1;
          end else begin
            w_tap <= w_tap + 3'd1;
          end
        end
        FILL: if (ia_fire) begin
          px_cnt <= px_cnt + 6'd1;
          // Oldest pixel sits at tap 0, the new one enters at tap k-1.
          for (int t = 0; t < MAX_K - 1; t++)
            if (t < int'(k_q) - 1) win[t] <= win[t+1];
          for (int t = 0; t < MAX_K; t++)
            if (t == int'(k_q) - 1) win[t] <= bus.ia_data;
        end
        EMIT: if (load) begin
          psum_q   <= dot;
          addr_q   <= addr_cnt;
          addr_cnt <= addr_cnt + 1'b1;
          if (last_oc) begin
            oc_cnt  <= '0;
            win_col <= win_col + 7'(stride_q);
          end else begin
            oc_cnt <= oc_cnt + 7'd1;
          end
        end
        DRAIN: begin
          if (ia_fire)               px_cnt <= px_cnt + 6'd1;
          if (all_in && !valid_q)    done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule
